// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared widths and resolver state encodings
package branch_resolver_pkg;
   localparam int DEF_WORD_SIZE = 16;
   localparam int DEF_CNT_W     = 16;
   typedef enum logic {RES_RUN = 1'b0, RES_SQUASH = 1'b1} res_state_e;
endpackage

// File: rtl/branch_resolver_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // increment only while below the maximum value
   always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
   // count register
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: checks IF-stage predictions in ID, redirects on mispredict, trains the BTB
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 if_valid,
   input  logic [WORD_SIZE-1:0] if_pc,
   input  logic [WORD_SIZE-1:0] if_pred_pc,
   input  logic                 if_pred_taken,
   input  logic                 stall,
   input  logic                 id_branch,
   input  logic                 id_jump,
   input  logic                 id_bcond,
   input  logic [WORD_SIZE-1:0] id_target,
   output logic [WORD_SIZE-1:0] id_pc,
   output logic                 redirect,
   output logic [WORD_SIZE-1:0] redirect_pc,
   output logic                 flush_if,
   output logic                 upd_branch,
   output logic                 upd_jump,
   output logic                 upd_bcond,
   output logic [WORD_SIZE-1:0] upd_target,
   output logic [CNT_W-1:0]     branch_cnt,
   output logic [CNT_W-1:0]     mispred_cnt
);
   res_state_e           state_q, state_d;
   logic                 valid_q, pred_taken_q;
   logic [WORD_SIZE-1:0] pc_q, pred_pc_q;
   logic                 resolve, mispredict;
   logic [WORD_SIZE-1:0] actual_next;
   // direction bit travels with the instruction for debug visibility only
   logic                 unused_pred_taken;
   assign unused_pred_taken = pred_taken_q;

   assign resolve     = reset_n & valid_q & ~stall & (state_q == RES_RUN);
   assign actual_next = (id_jump | (id_branch & id_bcond)) ? id_target : pc_q + WORD_SIZE'(1);
   assign mispredict  = resolve & (actual_next != pred_pc_q);

   assign id_pc       = pc_q;
   assign redirect    = mispredict;
   assign flush_if    = mispredict;
   assign redirect_pc = mispredict ? actual_next : '0;
   assign upd_branch  = resolve & id_branch;
   assign upd_jump    = resolve & id_jump;
   assign upd_bcond   = resolve & id_bcond;
   assign upd_target  = resolve ? id_target : '0;

   // IF/ID latch; a flushed fetch enters as a bubble
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         valid_q      <= 1'b0;
         pc_q         <= '0;
         pred_pc_q    <= '0;
         pred_taken_q <= 1'b0;
      end else if (!stall) begin
         valid_q      <= if_valid & ~mispredict;
         pc_q         <= if_pc;
         pred_pc_q    <= if_pred_pc;
         pred_taken_q <= if_pred_taken;
      end

   // resolver state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= RES_RUN;
      else          state_q <= state_d;

   // SQUASH blocks resolution for one unstalled cycle so each mispredict redirects once
   always_comb begin
      state_d = state_q;
      if (state_q == RES_RUN && mispredict) state_d = RES_SQUASH;
      else if (state_q == RES_SQUASH && !stall) state_d = RES_RUN;
   end

   sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk_i(clk), .reset_ni(reset_n), .inc_i(resolve & (id_branch | id_jump)), .cnt_o(branch_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
      .clk_i(clk), .reset_ni(reset_n), .inc_i(mispredict), .cnt_o(mispred_cnt)
   );
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors with a queued scoreboard checked at the falling edge
module tb_branch_resolver;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        if_valid, if_pred_taken, stall, id_branch, id_jump, id_bcond;
   logic [15:0] if_pc, if_pred_pc, id_target;
   logic [15:0] id_pc, redirect_pc, upd_target;
   logic        redirect, flush_if, upd_branch, upd_jump, upd_bcond;
   logic [3:0]  branch_cnt, mispred_cnt;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      string       name;
      logic [15:0] idpc;
      logic        rd;
      logic [15:0] rpc;
      logic        ub, uj, uc;
      logic [15:0] ut;
      logic [3:0]  bc, mc;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   branch_resolver #(.WORD_SIZE(16), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_pc(if_pc), .if_pred_pc(if_pred_pc),
      .if_pred_taken(if_pred_taken), .stall(stall), .id_branch(id_branch), .id_jump(id_jump),
      .id_bcond(id_bcond), .id_target(id_target), .id_pc(id_pc), .redirect(redirect),
      .redirect_pc(redirect_pc), .flush_if(flush_if), .upd_branch(upd_branch), .upd_jump(upd_jump),
      .upd_bcond(upd_bcond), .upd_target(upd_target), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic drv(input logic v, input logic [15:0] pc, input logic [15:0] ppc, input logic st,
                      input logic br, input logic jp, input logic bcd, input logic [15:0] tgt);
      @(posedge clk);
      #1;
      if_valid = v; if_pc = pc; if_pred_pc = ppc; if_pred_taken = (ppc != pc + 16'd1);
      stall = st; id_branch = br; id_jump = jp; id_bcond = bcd; id_target = tgt;
   endtask

   task automatic expect_out(input string n, input logic [15:0] idpc, input logic rd, input logic [15:0] rpc,
                             input logic ub, input logic uj, input logic uc, input logic [15:0] ut,
                             input logic [3:0] bc, input logic [3:0] mc);
      exp_t e;
      e.name = n; e.idpc = idpc; e.rd = rd; e.rpc = rpc; e.ub = ub; e.uj = uj; e.uc = uc;
      e.ut = ut; e.bc = bc; e.mc = mc;
      q.push_back(e);
   endtask

   // monitor: compares whatever expectation is pending against the settled outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".id_pc"}, id_pc, e.idpc);
            chk({e.name, ".redirect"}, 16'(redirect), 16'(e.rd));
            chk({e.name, ".flush_if"}, 16'(flush_if), 16'(e.rd));
            chk({e.name, ".redirect_pc"}, redirect_pc, e.rpc);
            chk({e.name, ".upd_branch"}, 16'(upd_branch), 16'(e.ub));
            chk({e.name, ".upd_jump"}, 16'(upd_jump), 16'(e.uj));
            chk({e.name, ".upd_bcond"}, 16'(upd_bcond), 16'(e.uc));
            chk({e.name, ".upd_target"}, upd_target, e.ut);
            chk({e.name, ".branch_cnt"}, 16'(branch_cnt), 16'(e.bc));
            chk({e.name, ".mispred_cnt"}, 16'(mispred_cnt), 16'(e.mc));
         end
      end
   end

   initial begin
      if_valid = 0; if_pc = 0; if_pred_pc = 0; if_pred_taken = 0; stall = 0;
      id_branch = 0; id_jump = 0; id_bcond = 0; id_target = 0;
      #3;
      chk("reset.redirect", 16'(redirect), 16'd0);
      chk("reset.redirect_pc", redirect_pc, 16'd0);
      chk("reset.id_pc", id_pc, 16'd0);
      chk("reset.branch_cnt", 16'(branch_cnt), 16'd0);
      chk("reset.mispred_cnt", 16'(mispred_cnt), 16'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      // fetch 0x0010 predicted fall-through
      drv(1, 16'h0010, 16'h0011, 0, 0, 0, 0, 16'h0000);
      expect_out("idle", 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd0, 4'd0);
      // branch not taken, prediction correct
      drv(1, 16'h0020, 16'h0021, 0, 1, 0, 0, 16'h0077);
      expect_out("nt_ok", 16'h0010, 0, 16'h0000, 1, 0, 0, 16'h0077, 4'd0, 4'd0);
      // branch taken, predicted fall-through: mispredict, wrong-path fetch discarded
      drv(1, 16'h0021, 16'h0022, 0, 1, 0, 1, 16'h0040);
      expect_out("tk_mis", 16'h0020, 1, 16'h0040, 1, 0, 1, 16'h0040, 4'd1, 4'd0);
      drv(1, 16'h0040, 16'h0041, 0, 1, 0, 1, 16'h0099);
      expect_out("squash", 16'h0021, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd2, 4'd1);
      drv(1, 16'h0030, 16'h0031, 0, 0, 0, 0, 16'h0000);
      expect_out("after_sq", 16'h0040, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd2, 4'd1);
      // jump held under two stall cycles, then resolves once
      drv(1, 16'h0031, 16'h0032, 1, 0, 1, 0, 16'h0100);
      expect_out("jmp_stall1", 16'h0030, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd2, 4'd1);
      drv(1, 16'h0031, 16'h0032, 1, 0, 1, 0, 16'h0100);
      expect_out("jmp_stall2", 16'h0030, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd2, 4'd1);
      drv(1, 16'h0031, 16'h0032, 0, 0, 1, 0, 16'h0100);
      expect_out("jmp_go", 16'h0030, 1, 16'h0100, 0, 1, 0, 16'h0100, 4'd2, 4'd1);
      drv(1, 16'hFFFF, 16'h0000, 0, 0, 1, 0, 16'h0100);
      expect_out("jmp_sq", 16'h0031, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd3, 4'd2);
      // wrap: 0xFFFF + 1 = 0x0000 matches prediction
      drv(1, 16'h0005, 16'h0050, 0, 0, 0, 0, 16'h0000);
      expect_out("wrap", 16'hFFFF, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd3, 4'd2);
      // alias hit on a non-branch
      drv(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
      expect_out("alias", 16'h0005, 1, 16'h0006, 0, 0, 0, 16'h0000, 4'd3, 4'd2);
      drv(1, 16'h0200, 16'h0300, 0, 0, 0, 0, 16'h0000);
      expect_out("alias_sq", 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd3, 4'd3);
      // repeated alias mispredicts drive the 4-bit counter into saturation
      for (int k = 0; k < 14; k++) begin
         drv(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
         expect_out($sformatf("sat_mis%0d", k), 16'h0200, 1, 16'h0201, 0, 0, 0, 16'h0000, 4'd3,
                    4'((3 + k > 15) ? 15 : 3 + k));
         drv(1, 16'h0200, 16'h0300, 0, 0, 0, 0, 16'h0000);
         expect_out($sformatf("sat_sq%0d", k), 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'd3,
                    4'((4 + k > 15) ? 15 : 4 + k));
      end
      // reset asserted while a redirect is active drops it immediately
      drv(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
      #1;
      chk("pre_reset.redirect", 16'(redirect), 16'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_reset.redirect", 16'(redirect), 16'd0);
      chk("mid_reset.flush_if", 16'(flush_if), 16'd0);
      chk("mid_reset.redirect_pc", redirect_pc, 16'd0);
      chk("mid_reset.id_pc", id_pc, 16'd0);
      chk("mid_reset.mispred_cnt", 16'(mispred_cnt), 16'd0);
      chk("mid_reset.branch_cnt", 16'(branch_cnt), 16'd0);
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 16'(q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
